// File: rtl/l15_anycore_resp_router_pkg.sv
// ============================================================================
// l15_anycore_resp_router_pkg : shared L1.5 / anycore definitions
// Return-type codes, address widths, cache geometry and small helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package l15_anycore_resp_router_pkg;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;

    localparam int L15_PADDR_WIDTH = 40;
    localparam int PHY_ADDR_WIDTH  = 40;

    localparam int ICACHE_TAG_BITS     = 52;
    localparam int ICACHE_INDEX_BITS   = 7;
    localparam int ICACHE_BITS_IN_LINE = 256;

    localparam int DCACHE_TAG_BITS     = 52;
    localparam int DCACHE_INDEX_BITS   = 6;
    localparam int DCACHE_BITS_IN_LINE = 512;

    typedef enum logic [2:0] {
        RC_LOAD  = 3'd0,
        RC_IFILL = 3'd1,
        RC_STACK = 3'd2,
        RC_INT   = 3'd3,
        RC_DROP  = 3'd4
    } resp_class_e;

    function automatic resp_class_e classify(input logic [3:0] rt);
        case (rt)
            LOAD_RET:  return RC_LOAD;
            IFILL_RET: return RC_IFILL;
            ST_ACK:    return RC_STACK;
            INT_RET:   return RC_INT;
            default:   return RC_DROP;
        endcase
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = w[8*(7-b) +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] sext_paddr(input logic [PHY_ADDR_WIDTH-1:0] a);
        return {{(64-PHY_ADDR_WIDTH){a[PHY_ADDR_WIDTH-1]}}, a};
    endfunction

endpackage

`default_nettype wire

// File: rtl/l15_anycore_resp_router_fifo.sv
// ============================================================================
// l15_resp_fifo : circular response buffer with occupancy count
// Head is presented combinationally; push refused when full.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l15_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l15_anycore_resp_router.sv
// ============================================================================
// l15_anycore_resp_router : steers L1.5 responses to anycore i/d caches,
// store-ack and interrupt pulses; tracks per-thread outstanding ld/st.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l15_anycore_resp_router
    import l15_anycore_resp_router_pkg::*;
#(
    parameter int NUM_THREADS = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           l15_val,
    input  logic [3:0]                     l15_returntype,
    input  logic [TID_W-1:0]               l15_threadid,
    input  logic [L15_PADDR_WIDTH-1:0]     l15_address,
    input  logic [255:0]                   l15_data,
    output logic                           l15_ack,

    input  logic                           ic_ready,
    output logic                           ic_respvalid,
    output logic [ICACHE_TAG_BITS-1:0]     ic_tag,
    output logic [ICACHE_INDEX_BITS-1:0]   ic_index,
    output logic [ICACHE_BITS_IN_LINE-1:0] ic_data,

    input  logic                           dc_ready,
    output logic                           dc_ldvalid,
    output logic [TID_W-1:0]               dc_ldthread,
    output logic [DCACHE_TAG_BITS-1:0]     dc_ldtag,
    output logic [DCACHE_INDEX_BITS-1:0]   dc_ldindex,
    output logic [DCACHE_BITS_IN_LINE-1:0] dc_lddata,

    input  logic [NUM_THREADS-1:0]         dc_ldreq,
    input  logic [NUM_THREADS-1:0]         dc_streq,
    output logic [NUM_THREADS-1:0]         dc_stcomplete,
    output logic [NUM_THREADS-1:0]         dc_ststall,
    output logic [NUM_THREADS-1:0]         core_int
);

    localparam int ENTRY_W = 4 + TID_W + L15_PADDR_WIDTH + 256;
    localparam int IC_OFF  = 64 - ICACHE_TAG_BITS - ICACHE_INDEX_BITS;
    localparam int DC_OFF  = 64 - DCACHE_TAG_BITS - DCACHE_INDEX_BITS;
    localparam int OFF_LO  = (IC_OFF < DC_OFF) ? IC_OFF : DC_OFF;

    logic [ENTRY_W-1:0]         push_entry;
    logic [ENTRY_W-1:0]         head_entry;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       head_valid;
    logic                       head_pop;
    logic [3:0]                 head_rt;
    logic [TID_W-1:0]           head_tid;
    logic [L15_PADDR_WIDTH-1:0] head_addr;
    logic [255:0]               head_data;
    resp_class_e                head_cls;
    logic [255:0]               head_line;
    logic [63:0]                head_addr64;
    logic                       unused_addr_lsbs;

    logic [NUM_THREADS-1:0]     ld_active_q, ld_active_d;
    logic [NUM_THREADS-1:0]     st_active_q, st_active_d;
    logic [NUM_THREADS-1:0]     ld_clr;

    // Acceptance looks only at registered occupancy, so a pop in the same
    // cycle never opens a slot for the incoming response.
    assign l15_ack    = rst_n & l15_val & ~fifo_full;
    assign push_entry = {l15_returntype, l15_threadid, l15_address, l15_data};

    l15_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (l15_ack),
        .pop_i   (head_pop),
        .data_i  (push_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_entry)
    );

    assign {head_rt, head_tid, head_addr, head_data} = head_entry;
    assign head_cls   = classify(head_rt);
    assign head_valid = rst_n & ~fifo_empty;

    assign ic_respvalid = head_valid & (head_cls == RC_IFILL);
    assign dc_ldvalid   = head_valid & (head_cls == RC_LOAD);

    assign head_pop = head_valid & (ic_respvalid ? ic_ready :
                                    dc_ldvalid   ? dc_ready : 1'b1);

    assign head_line = {bswap64(head_data[255:192]), bswap64(head_data[191:128]),
                        bswap64(head_data[127:64]),  bswap64(head_data[63:0])};

    assign head_addr64      = sext_paddr(head_addr);
    assign unused_addr_lsbs = ^head_addr64[OFF_LO-1:0];

    assign ic_tag   = head_addr64[63 -: ICACHE_TAG_BITS];
    assign ic_index = head_addr64[63-ICACHE_TAG_BITS -: ICACHE_INDEX_BITS];
    assign ic_data  = head_line;

    assign dc_ldthread = head_tid;
    assign dc_ldtag    = head_addr64[63 -: DCACHE_TAG_BITS];
    assign dc_ldindex  = head_addr64[63-DCACHE_TAG_BITS -: DCACHE_INDEX_BITS];
    assign dc_lddata   = {(DCACHE_BITS_IN_LINE/256){head_line}};

    // Thread ids at or above NUM_THREADS match no slice and are dropped.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        logic tid_hit;
        assign tid_hit          = (head_tid == TID_W'(t));
        assign dc_stcomplete[t] = head_valid & (head_cls == RC_STACK) & tid_hit;
        assign core_int[t]      = head_valid & (head_cls == RC_INT) & tid_hit &
                                  (head_data[17:16] == 2'b01);
        assign ld_clr[t]        = dc_ldvalid & dc_ready & tid_hit;
    end

    assign ld_active_d = (ld_active_q | dc_ldreq) & ~ld_clr;
    assign st_active_d = (st_active_q | dc_streq) & ~dc_stcomplete;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_active_q <= '0;
            st_active_q <= '0;
        end else begin
            ld_active_q <= ld_active_d;
            st_active_q <= st_active_d;
        end
    end

    assign dc_ststall = ((st_active_q | ld_active_q) & {NUM_THREADS{rst_n}}) |
                        dc_streq | dc_ldreq;

endmodule

`default_nettype wire

// File: tb/tb_l15_anycore_resp_router.sv
// ============================================================================
// tb_l15_anycore_resp_router : directed + random bench with queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_l15_anycore_resp_router;
    import l15_anycore_resp_router_pkg::*;

    localparam int NT    = 2;
    localparam int DEPTH = 4;
    localparam int TW    = (NT > 1) ? $clog2(NT) : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst_n;
    logic                           l15_val;
    logic [3:0]                     l15_returntype;
    logic [TW-1:0]                  l15_threadid;
    logic [L15_PADDR_WIDTH-1:0]     l15_address;
    logic [255:0]                   l15_data;
    logic                           l15_ack;
    logic                           ic_ready;
    logic                           ic_respvalid;
    logic [ICACHE_TAG_BITS-1:0]     ic_tag;
    logic [ICACHE_INDEX_BITS-1:0]   ic_index;
    logic [ICACHE_BITS_IN_LINE-1:0] ic_data;
    logic                           dc_ready;
    logic                           dc_ldvalid;
    logic [TW-1:0]                  dc_ldthread;
    logic [DCACHE_TAG_BITS-1:0]     dc_ldtag;
    logic [DCACHE_INDEX_BITS-1:0]   dc_ldindex;
    logic [DCACHE_BITS_IN_LINE-1:0] dc_lddata;
    logic [NT-1:0]                  dc_ldreq;
    logic [NT-1:0]                  dc_streq;
    logic [NT-1:0]                  dc_stcomplete;
    logic [NT-1:0]                  dc_ststall;
    logic [NT-1:0]                  core_int;

    l15_anycore_resp_router #(
        .NUM_THREADS (NT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .l15_val        (l15_val),
        .l15_returntype (l15_returntype),
        .l15_threadid   (l15_threadid),
        .l15_address    (l15_address),
        .l15_data       (l15_data),
        .l15_ack        (l15_ack),
        .ic_ready       (ic_ready),
        .ic_respvalid   (ic_respvalid),
        .ic_tag         (ic_tag),
        .ic_index       (ic_index),
        .ic_data        (ic_data),
        .dc_ready       (dc_ready),
        .dc_ldvalid     (dc_ldvalid),
        .dc_ldthread    (dc_ldthread),
        .dc_ldtag       (dc_ldtag),
        .dc_ldindex     (dc_ldindex),
        .dc_lddata      (dc_lddata),
        .dc_ldreq       (dc_ldreq),
        .dc_streq       (dc_streq),
        .dc_stcomplete  (dc_stcomplete),
        .dc_ststall     (dc_ststall),
        .core_int       (core_int)
    );

    typedef struct packed {
        logic [3:0]                 rt;
        logic [TW-1:0]              tid;
        logic [L15_PADDR_WIDTH-1:0] addr;
        logic [255:0]               data;
    } ent_t;

    ent_t    q[$];
    logic [NT-1:0] m_ld = '0;
    logic [NT-1:0] m_st = '0;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte b of the line comes from byte (7 - b%8) of the same 64-bit word.
    function automatic logic [255:0] exp_line(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[8*((i/8)*8 + 7 - (i%8)) +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] addr64(input logic [L15_PADDR_WIDTH-1:0] a);
        logic [63:0] r;
        r = 64'(a);
        if (a[PHY_ADDR_WIDTH-1]) r = r | (~64'd0 << PHY_ADDR_WIDTH);
        return r;
    endfunction

    function automatic logic [63:0] exp_tag(input logic [L15_PADDR_WIDTH-1:0] a, input int tb);
        return addr64(a) >> (64 - tb);
    endfunction

    function automatic logic [63:0] exp_idx(input logic [L15_PADDR_WIDTH-1:0] a, input int tb, input int ib);
        return (addr64(a) >> (64 - tb - ib)) & ((64'd1 << ib) - 64'd1);
    endfunction

    // One clock: check all outputs at the falling edge, advance model after the rising edge.
    task automatic cycle();
        logic    hv, e_ack, e_icv, e_ldv, e_pop;
        ent_t    h, inb;
        logic [NT-1:0] e_stc, e_int, e_clr, e_ss;
        @(negedge clk);
        hv    = rst_n && (q.size() > 0);
        h     = hv ? q[0] : '0;
        inb   = {l15_returntype, l15_threadid, l15_address, l15_data};
        e_ack = rst_n && l15_val && (q.size() < DEPTH);
        e_icv = hv && (h.rt == IFILL_RET);
        e_ldv = hv && (h.rt == LOAD_RET);
        e_stc = '0;
        e_int = '0;
        e_clr = '0;
        if (hv && int'(h.tid) < NT) begin
            if (h.rt == ST_ACK) e_stc[h.tid] = 1'b1;
            if (h.rt == INT_RET && h.data[17:16] == 2'b01) e_int[h.tid] = 1'b1;
            if (e_ldv && dc_ready) e_clr[h.tid] = 1'b1;
        end
        e_pop = hv && (e_icv ? ic_ready : (e_ldv ? dc_ready : 1'b1));
        e_ss  = rst_n ? (m_st | m_ld | dc_streq | dc_ldreq) : (dc_streq | dc_ldreq);
        chk("l15_ack",       512'(l15_ack),       512'(e_ack));
        chk("ic_respvalid",  512'(ic_respvalid),  512'(e_icv));
        chk("dc_ldvalid",    512'(dc_ldvalid),    512'(e_ldv));
        chk("dc_stcomplete", 512'(dc_stcomplete), 512'(e_stc));
        chk("core_int",      512'(core_int),      512'(e_int));
        chk("dc_ststall",    512'(dc_ststall),    512'(e_ss));
        if (e_icv) begin
            chk("ic_tag",   512'(ic_tag),   512'(exp_tag(h.addr, ICACHE_TAG_BITS)));
            chk("ic_index", 512'(ic_index), 512'(exp_idx(h.addr, ICACHE_TAG_BITS, ICACHE_INDEX_BITS)));
            chk("ic_data",  512'(ic_data),  512'(exp_line(h.data)));
        end
        if (e_ldv) begin
            chk("dc_ldthread", 512'(dc_ldthread), 512'(h.tid));
            chk("dc_ldtag",    512'(dc_ldtag),    512'(exp_tag(h.addr, DCACHE_TAG_BITS)));
            chk("dc_ldindex",  512'(dc_ldindex),  512'(exp_idx(h.addr, DCACHE_TAG_BITS, DCACHE_INDEX_BITS)));
            chk("dc_lddata",   512'(dc_lddata),   {exp_line(h.data), exp_line(h.data)});
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_ld = '0;
            m_st = '0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_ack) q.push_back(inb);
            m_ld = (m_ld | dc_ldreq) & ~e_clr;
            m_st = (m_st | dc_streq) & ~e_stc;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rt, input logic [TW-1:0] tid,
                         input logic [L15_PADDR_WIDTH-1:0] a, input logic [255:0] d);
        l15_val        = v;
        l15_returntype = rt;
        l15_threadid   = tid;
        l15_address    = a;
        l15_data       = d;
    endtask

    initial begin
        logic [63:0] r64;
        rst_n    = 1'b0;
        ic_ready = 1'b0;
        dc_ready = 1'b0;
        dc_ldreq = '0;
        dc_streq = 2'b01;
        drive(1'b1, LOAD_RET, '0, '0, '0);

        // Reset: no acceptance, stall follows live requests only.
        cycle();
        cycle();
        dc_streq = '0;
        rst_n    = 1'b1;
        drive(1'b0, LOAD_RET, '0, '0, '0);
        cycle();

        // Instruction fill with byte-swapped first word.
        ic_ready = 1'b1;
        drive(1'b1, IFILL_RET, '0, 40'h00_8000_1040, 256'h0011223344556677);
        cycle();
        drive(1'b0, LOAD_RET, '0, '0, '0);
        #1;
        chk("ifill_valid", 512'(ic_respvalid), 512'(1'b1));
        chk("ifill_word0", 512'(ic_data[63:0]), 512'(64'h7766554433221100));
        chk("ifill_tag",   512'(ic_tag), 512'(52'h80001));
        chk("ifill_index", 512'(ic_index), 512'(7'h02));
        cycle();
        cycle();

        // Fill all four slots with loads held back by dc_ready.
        dc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, LOAD_RET, TW'(i), 40'h12_3456_7000 + 40'(i * 64), 256'(i + 1) << 8);
            if (i == 4) begin
                #1;
                chk("full_ack", 512'(l15_ack), 512'(1'b0));
            end
            cycle();
        end
        dc_ready = 1'b1;
        #1;
        chk("pop_cycle_ack", 512'(l15_ack), 512'(1'b0));
        chk("pop_cycle_ldv", 512'(dc_ldvalid), 512'(1'b1));
        cycle();
        #1;
        chk("ack_resumes", 512'(l15_ack), 512'(1'b1));
        cycle();
        drive(1'b0, LOAD_RET, '0, '0, '0);
        for (int i = 0; i < 5; i++) cycle();

        // Store tracker on thread 1.
        dc_streq = 2'b10;
        cycle();
        dc_streq = '0;
        cycle();
        #1;
        chk("st_stall_held", 512'(dc_ststall), 512'(2'b10));
        drive(1'b1, ST_ACK, 1'b1, '0, '0);
        cycle();
        drive(1'b0, LOAD_RET, '0, '0, '0);
        #1;
        chk("stcomplete_pulse", 512'(dc_stcomplete), 512'(2'b10));
        cycle();
        #1;
        chk("st_stall_clear", 512'(dc_ststall), 512'(2'b00));
        chk("stcomplete_done", 512'(dc_stcomplete), 512'(2'b00));
        cycle();

        // Interrupt wakeup: only code 01 in data_0[17:16] raises core_int.
        drive(1'b1, INT_RET, 1'b0, '0, 256'h1_0000);
        cycle();
        drive(1'b0, LOAD_RET, '0, '0, '0);
        #1;
        chk("int_pulse", 512'(core_int), 512'(2'b01));
        cycle();
        #1;
        chk("int_single", 512'(core_int), 512'(2'b00));
        drive(1'b1, INT_RET, 1'b0, '0, 256'h2_0000);
        cycle();
        drive(1'b1, IFILL_RET, 1'b0, 40'h80_0000_0020, 256'hA5);
        #1;
        chk("int_nopulse", 512'(core_int), 512'(2'b00));
        cycle();
        drive(1'b0, LOAD_RET, '0, '0, '0);
        cycle();
        cycle();

        // Full + pop collision, then reset with entries buffered.
        dc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, LOAD_RET, TW'(i), 40'h00_0000_1000 + 40'(i), 256'(i + 7));
            cycle();
        end
        dc_ready = 1'b1;
        cycle();
        dc_ready = 1'b0;
        drive(1'b0, LOAD_RET, '0, '0, '0);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("rst_ldvalid", 512'(dc_ldvalid), 512'(1'b0));
        chk("rst_icvalid", 512'(ic_respvalid), 512'(1'b0));
        cycle();

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            l15_val = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 4))
                0:       l15_returntype = LOAD_RET;
                1:       l15_returntype = IFILL_RET;
                2:       l15_returntype = ST_ACK;
                3:       l15_returntype = INT_RET;
                default: l15_returntype = 4'($urandom);
            endcase
            l15_threadid = TW'($urandom);
            r64          = {$urandom, $urandom};
            l15_address  = L15_PADDR_WIDTH'(r64);
            for (int k = 0; k < 8; k++) l15_data[32*k +: 32] = $urandom;
            ic_ready = ($urandom_range(0, 99) < 70);
            dc_ready = ($urandom_range(0, 99) < 70);
            dc_ldreq = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
            dc_streq = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/l15_anycore_resp_router.md
L15_ANYCORE_RESP_ROUTER -- requirements
Module: l15_anycore_resp_router

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 2, meaning the number of core hardware threads (1..4); TID_W = max(1, clog2(NUM_THREADS)).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning response buffer entries (power of 2, 2..16).
REQ-003 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port l15_val, input, 1, L1.5 response valid.
REQ-006 SHALL have port l15_returntype, input, 4, L1.5 return type (LOAD_RET, IFILL_RET, ST_ACK, INT_RET; others unknown).
REQ-007 SHALL have port l15_threadid, input, TID_W, response thread.
REQ-008 SHALL have port l15_address, input, L15_PADDR width, response physical address.
REQ-009 SHALL have port l15_data, input, 256, {data_3,data_2,data_1,data_0}, each 64-bit word big-endian.
REQ-010 SHALL have port l15_ack, output, 1, response accepted this cycle.
REQ-011 SHALL have ports ic_ready, input, 1, and ic_respvalid, output, 1, icache fill handshake; ic_tag, ic_index, ic_data (ICACHE_TAG_BITS, ICACHE_INDEX_BITS, ICACHE_BITS_IN_LINE), outputs.
REQ-012 SHALL have ports dc_ready, input, 1, and dc_ldvalid, output, 1, dcache load-return handshake; dc_ldthread (TID_W), dc_ldtag, dc_ldindex, dc_lddata (DCACHE_*), outputs.
REQ-013 SHALL have ports dc_ldreq, dc_streq, inputs, NUM_THREADS, per-thread new load/store request pulses.
REQ-014 SHALL have ports dc_stcomplete, dc_ststall, core_int, outputs, NUM_THREADS, per-thread store ack pulse, request stall, wakeup-interrupt pulse.

Function
REQ-015 SHALL set l15_ack = l15_val & ~full, using registered occupancy only (no same-cycle pop bypass).
REQ-016 SHALL push {returntype, threadid, address, data} when l15_ack; full/empty from a count of 0..FIFO_DEPTH with pointer wrap at FIFO_DEPTH.
REQ-017 SHALL present the FIFO head on outputs combinationally; a pushed entry is first visible the cycle after push (minimum latency 1).
REQ-018 SHALL pop IFILL_RET head when ic_ready (ic_respvalid = head valid & IFILL_RET); LOAD_RET head when dc_ready; ST_ACK, INT_RET and unknown heads unconditionally in one cycle.
REQ-019 SHALL, while a head waits on ready, hold all head outputs stable and keep the valid asserted.
REQ-020 SHALL byte-reverse each 64-bit word; ic_data = {swap(d3),swap(d2),swap(d1),swap(d0)}; dc_lddata = that 256-bit line replicated to DCACHE_BITS_IN_LINE.
REQ-021 SHALL sign-extend address to 64 bits from bit PHY_ADDR_WIDTH-1; tag = top TAG_BITS, index = next INDEX_BITS, per cache.
REQ-022 SHALL pulse dc_stcomplete[tid] one cycle on ST_ACK pop; pulse core_int[tid] one cycle on INT_RET pop with data_0[17:16]==2'b01; drop other INT_RET and unknown types silently.
REQ-023 SHALL keep per-thread ld_active/st_active: set by dc_ldreq[t]/dc_streq[t], cleared by dc_ldvalid&dc_ready&thread t / dc_stcomplete[t]; clear wins when simultaneous.
REQ-024 SHALL drive dc_ststall[t] = st_active[t] | ld_active[t] | dc_streq[t] | dc_ldreq[t].
REQ-025 SHALL ignore threadid values >= NUM_THREADS for pulses and tracker clears (entry still popped).

Reset
REQ-026 SHALL, while rst_n low at a clock edge, clear pointers, count, trackers; outputs l15_ack=0 (when full irrelevant: empty), ic_respvalid=0, dc_ldvalid=0, dc_stcomplete=0, core_int=0, dc_ststall=dc_streq|dc_ldreq; buffered entries discarded on reset mid-operation.

Structure
REQ-027 SHALL take return-type codes, PADDR/PHY_ADDR_WIDTH and cache geometry from the shared l15/anycore define package; no local redefinition.
REQ-028 SHALL instantiate one sub-module l15_resp_fifo (parameterised width/depth, push/pop/full/empty/head).

Verification
REQ-029 IFILL_RET addr 0x8000_1040, data_0=0x0011223344556677, ic_ready=1 -> ic_respvalid next cycle, ic_data[63:0]=0x7766554433221100.
REQ-030 Push 4 LOAD_RET with dc_ready=0 (depth 4) -> 5th l15_val gets l15_ack=0; dc_ready=1 -> four dc_ldvalid in order, ack resumes cycle after first pop.
REQ-031 dc_streq[1] pulse -> dc_ststall[1]=1 held; ST_ACK tid1 -> dc_stcomplete[1] pulse, dc_ststall[1]=0 next cycle; thread 0 unaffected.
REQ-032 INT_RET tid0 data_0[17:16]=01 -> core_int[0] single pulse; same with 10 -> no pulse, entry popped.
REQ-033 Simultaneous push into full FIFO and pop; rst_n low with 3 entries buffered -> empty, all valids 0 next cycle.
